// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg
//   Shared ISA definitions for the CPU front end.
//   Instruction word layout (38 bits): {opcode[3:0], s[1:0], a[15:0], b[15:0]}
//   Contents:
//     opcode_e     - opcode encodings
//     *_MSB/*_LSB  - bit positions of each instruction field
//     fsm_state_t  - fetch/decode sequencer states
//     is_branch()  - opcode is resolved locally, never issued
//     is_issue()   - opcode is handed to the execute stage
package cpu_isa_pkg;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    MOV = 4'd1,
    LDR = 4'd2,
    STR = 4'd3,
    CMP = 4'd4,
    B   = 4'd5,
    BGT = 4'd6,
    BLT = 4'd7,
    BEQ = 4'd8,
    ADD = 4'd9
  } opcode_e;

  localparam int OP_MSB = 37;
  localparam int OP_LSB = 34;
  localparam int S_MSB  = 33;
  localparam int S_LSB  = 32;
  localparam int A_MSB  = 31;
  localparam int A_LSB  = 16;
  localparam int B_MSB  = 15;
  localparam int B_LSB  = 0;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    ISSUE  = 3'd2,
    BRANCH = 3'd3,
    HALT   = 3'd4
  } fsm_state_t;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == B) || (op == BGT) || (op == BLT) || (op == BEQ);
  endfunction

  function automatic logic is_issue(input logic [3:0] op);
    return (op <= 4'd4) || (op == ADD);
  endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// instr_fetch_decode_if
//   Bundles the ROM bus, the decoded-instruction handshake and the flag
//   return path between the fetch/decode front end and its environment.
//   Modports:
//     master - the front end: drives address, dec_*, halted
//     slave  - ROM + execute stage: drives instruction, dec_ready,
//              exec_idle and the compare flags
interface instr_fetch_decode_if #(
  parameter int DATA_WIDTH = 38,
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  dec_valid;
  logic                  dec_ready;
  logic [3:0]            dec_opcode;
  logic [1:0]            dec_mode;
  logic [15:0]           dec_a;
  logic [15:0]           dec_b;
  logic                  exec_idle;
  logic                  flag_gt;
  logic                  flag_lt;
  logic                  flag_eq;
  logic                  halted;

  modport master (
    output address, dec_valid, dec_opcode, dec_mode, dec_a, dec_b, halted,
    input  instruction, dec_ready, exec_idle, flag_gt, flag_lt, flag_eq
  );

  modport slave (
    input  address, dec_valid, dec_opcode, dec_mode, dec_a, dec_b, halted,
    output instruction, dec_ready, exec_idle, flag_gt, flag_lt, flag_eq
  );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve
//   Combinational branch decision for b/bgt/blt/beq.
//   Ports:
//     opcode   - branch opcode held in the instruction register
//     target   - low ADDR_WIDTH bits of the b field (upper bits ignored)
//     pc       - current program counter
//     flag_*   - compare flags from the execute stage
//     taken    - branch is taken
//     next_pc  - taken ? target : pc+1 (modulo 2^ADDR_WIDTH)
module branch_resolve
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic [3:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] target,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flag_gt,
  input  logic                  flag_lt,
  input  logic                  flag_eq,
  output logic                  taken,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      B:       taken = 1'b1;
      BGT:     taken = flag_gt;
      BLT:     taken = flag_lt;
      BEQ:     taken = flag_eq;
      default: taken = 1'b0;
    endcase
    next_pc = taken ? target : pc + 1'b1;
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode
//   CPU front end: owns the PC, reads the asynchronous instruction ROM,
//   decodes each word, issues non-branch instructions to the execute stage
//   and resolves branches locally once the execute stage is idle.
//   Sequencer: FETCH -> DECODE -> ISSUE | BRANCH | HALT -> FETCH
//   Ports:
//     clk, rst    - clock (rising edge), asynchronous active-high reset
//     bus         - instr_fetch_decode_if.master: ROM address/data,
//                   dec_* valid/ready handshake, exec_idle, flags, halted
//     issue_cnt   - (IFD_PERF_CNT_EN only) saturating count of handshakes
//     taken_cnt   - (IFD_PERF_CNT_EN only) saturating count of taken branches
//   Optional build macro: IFD_PERF_CNT_EN enables the two perf counters.
module instr_fetch_decode
  import cpu_isa_pkg::*;
#(
  parameter int DATA_WIDTH = 38,
  parameter int ADDR_WIDTH = 12
) (
  input  logic clk,
  input  logic rst,
  instr_fetch_decode_if.master bus
`ifdef IFD_PERF_CNT_EN
  ,
  output logic [15:0] issue_cnt,
  output logic [15:0] taken_cnt
`endif
);

  fsm_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  dec_valid_q, dec_valid_d;
  logic [3:0]            dec_opcode_q, dec_opcode_d;
  logic [1:0]            dec_mode_q, dec_mode_d;
  logic [15:0]           dec_a_q, dec_a_d;
  logic [15:0]           dec_b_q, dec_b_d;
  logic                  halted_q, halted_d;

  logic [3:0]            ir_op;
  logic                  br_taken;
  logic [ADDR_WIDTH-1:0] br_next_pc;
  logic                  handshake;

  assign ir_op     = ir_q[OP_MSB:OP_LSB];
  assign handshake = dec_valid_q && bus.dec_ready;

  branch_resolve #(.ADDR_WIDTH(ADDR_WIDTH)) u_branch_resolve (
    .opcode  (ir_op),
    .target  (ir_q[ADDR_WIDTH-1:0]),
    .pc      (pc_q),
    .flag_gt (bus.flag_gt),
    .flag_lt (bus.flag_lt),
    .flag_eq (bus.flag_eq),
    .taken   (br_taken),
    .next_pc (br_next_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    dec_valid_d  = dec_valid_q;
    dec_opcode_d = dec_opcode_q;
    dec_mode_d   = dec_mode_q;
    dec_a_d      = dec_a_q;
    dec_b_d      = dec_b_q;
    halted_d     = halted_q;

    case (state_q)
      FETCH: begin
        ir_d    = bus.instruction;
        state_d = DECODE;
      end
      DECODE: begin
        if (is_branch(ir_op)) begin
          state_d = BRANCH;
        end else if (is_issue(ir_op)) begin
          dec_opcode_d = ir_q[OP_MSB:OP_LSB];
          dec_mode_d   = ir_q[S_MSB:S_LSB];
          dec_a_d      = ir_q[A_MSB:A_LSB];
          dec_b_d      = ir_q[B_MSB:B_LSB];
          dec_valid_d  = 1'b1;
          state_d      = ISSUE;
        end else begin
          halted_d = 1'b1;
          state_d  = HALT;
        end
      end
      ISSUE: begin
        // Payload registers are untouched here, so they stay stable
        // for as long as the execute stage applies backpressure.
        if (handshake) begin
          pc_d        = pc_q + 1'b1;
          dec_valid_d = 1'b0;
          state_d     = FETCH;
        end
      end
      BRANCH: begin
        // Flags only mean something once every issued instruction
        // has retired, so they are looked at only when exec_idle is high.
        if (bus.exec_idle) begin
          pc_d    = br_next_pc;
          state_d = FETCH;
        end
      end
      HALT: begin
        dec_valid_d = 1'b0;
        halted_d    = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      dec_valid_q  <= 1'b0;
      dec_opcode_q <= '0;
      dec_mode_q   <= '0;
      dec_a_q      <= '0;
      dec_b_q      <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      dec_valid_q  <= dec_valid_d;
      dec_opcode_q <= dec_opcode_d;
      dec_mode_q   <= dec_mode_d;
      dec_a_q      <= dec_a_d;
      dec_b_q      <= dec_b_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.address    = pc_q;
  assign bus.dec_valid  = dec_valid_q;
  assign bus.dec_opcode = dec_opcode_q;
  assign bus.dec_mode   = dec_mode_q;
  assign bus.dec_a      = dec_a_q;
  assign bus.dec_b      = dec_b_q;
  assign bus.halted     = halted_q;

`ifdef IFD_PERF_CNT_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (state_q == ISSUE && handshake && issue_cnt_q != 16'hFFFF)
      issue_cnt_d = issue_cnt_q + 16'd1;
    if (state_q == BRANCH && bus.exec_idle && br_taken && taken_cnt_q != 16'hFFFF)
      taken_cnt_d = taken_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode
//   Drives instr_fetch_decode from a bench-owned ROM image and follows the
//   program with a transaction-level model: one expected PC, one decision
//   per instruction (issue / branch taken or not / halt).
module tb_instr_fetch_decode;
  import cpu_isa_pkg::*;

  localparam int DW = 38;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_decode_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic [DW-1:0] rom [0:4095];
  assign bus.instruction = rom[bus.address];

`ifdef IFD_PERF_CNT_EN
  logic [15:0] issue_cnt;
  logic [15:0] taken_cnt;
`endif

  instr_fetch_decode #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IFD_PERF_CNT_EN
    ,
    .issue_cnt (issue_cnt),
    .taken_cnt (taken_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_pc;
  int exp_issues;
  int exp_taken;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] word(input logic [3:0] op, input logic [1:0] s,
                                         input logic [15:0] a, input logic [15:0] b);
    return {op, s, a, b};
  endfunction

  task automatic rand_flags();
    bus.flag_gt = 1'($urandom);
    bus.flag_lt = 1'($urandom);
    bus.flag_eq = 1'($urandom);
  endtask

  // Asserted a few ns after an edge so the asynchronous clear is observed
  // well before the following edge.
  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    chk("rst_async_addr", bus.address, 0);
    chk("rst_async_valid", bus.dec_valid, 0);
    tick();
    chk("rst_halted", bus.halted, 0);
    chk("rst_opcode", bus.dec_opcode, 0);
    chk("rst_mode", bus.dec_mode, 0);
    chk("rst_a", bus.dec_a, 0);
    chk("rst_b", bus.dec_b, 0);
    rst = 1'b0;
    exp_pc = '0;
    exp_issues = 0;
    exp_taken = 0;
`ifdef IFD_PERF_CNT_EN
    chk("rst_issue_cnt", issue_cnt, 0);
    chk("rst_taken_cnt", taken_cnt, 0);
`endif
  endtask

  // Executes one legal instruction at exp_pc; stall = extra cycles of
  // backpressure (issue) or of exec_idle low (branch).
  task automatic step(input int txn, input int stall);
    logic [DW-1:0] w;
    logic [3:0] op;
    logic taken;
    logic [AW-1:0] pc_before;
    w = rom[exp_pc];
    op = w[37:34];
    pc_before = exp_pc;
    taken = 1'b0;
    chk("fetch_addr", bus.address, exp_pc);
    chk("fetch_valid", bus.dec_valid, 0);
    chk("fetch_halted", bus.halted, 0);
    bus.dec_ready = 1'b0;
    bus.exec_idle = 1'b0;
    tick();
    chk("decode_valid", bus.dec_valid, 0);
    chk("decode_addr", bus.address, exp_pc);
    tick();
    if (op <= 4'd4 || op == 4'd9) begin
      for (int i = 0; i <= stall; i++) begin
        chk("issue_valid", bus.dec_valid, 1);
        chk("issue_opcode", bus.dec_opcode, op);
        chk("issue_mode", bus.dec_mode, w[33:32]);
        chk("issue_a", bus.dec_a, w[31:16]);
        chk("issue_b", bus.dec_b, w[15:0]);
        chk("issue_addr", bus.address, exp_pc);
        rand_flags();
        bus.exec_idle = 1'($urandom);
        if (i == stall) bus.dec_ready = 1'b1;
        tick();
      end
      bus.dec_ready = 1'b0;
      exp_pc = exp_pc + 12'd1;
      exp_issues++;
    end else begin
      for (int i = 0; i <= stall; i++) begin
        chk("branch_valid", bus.dec_valid, 0);
        chk("branch_addr", bus.address, exp_pc);
        rand_flags();
        bus.dec_ready = 1'($urandom);
        if (i == stall) begin
          bus.exec_idle = 1'b1;
          taken = (op == 4'd5) || (op == 4'd6 && bus.flag_gt) ||
                  (op == 4'd7 && bus.flag_lt) || (op == 4'd8 && bus.flag_eq);
        end
        tick();
      end
      bus.exec_idle = 1'b0;
      bus.dec_ready = 1'b0;
      exp_pc = taken ? w[AW-1:0] : exp_pc + 12'd1;
      if (taken) exp_taken++;
    end
    $display("txn %0d pc=%03h op=%0d stall=%0d taken=%0d next=%03h",
             txn, pc_before, op, stall, taken, exp_pc);
  endtask

  initial begin
    rst = 1'b1;
    bus.dec_ready = 1'b0;
    bus.exec_idle = 1'b0;
    bus.flag_gt = 1'b0;
    bus.flag_lt = 1'b0;
    bus.flag_eq = 1'b0;
    exp_pc = '0;
    exp_issues = 0;
    exp_taken = 0;

    // Random legal program; branch b fields carry random upper bits.
    for (int a = 0; a < 4096; a++)
      rom[a] = word(4'($urandom_range(0, 9)), 2'($urandom), 16'($urandom), 16'($urandom));
    rom[0]     = word(NOP, 2'd0, 16'h0000, 16'h0000);
    rom[1]     = word(MOV, 2'd0, 16'h0000, 16'h0001);
    rom[2]     = word(MOV, 2'd0, 16'h1000, 16'h0002);
    rom[3]     = word(B,   2'd0, 16'h0000, 16'hF060);
    rom[12'h060] = word(BGT, 2'd0, 16'h0000, 16'h0062);
    rom[12'h061] = word(BLT, 2'd0, 16'h0000, 16'h0069);
    rom[12'h062] = word(BEQ, 2'd0, 16'h0000, 16'h0069);
    rom[12'h069] = word(B,   2'd0, 16'h0000, 16'h7100);

    tick();
    tick();
    chk("init_addr", bus.address, 0);
    chk("init_valid", bus.dec_valid, 0);
    chk("init_halted", bus.halted, 0);
    chk("init_opcode", bus.dec_opcode, 0);
    chk("init_a", bus.dec_a, 0);
    chk("init_b", bus.dec_b, 0);
    rst = 1'b0;

    // Run 1: stream, backpressure, branches, then random program.
    step(0, 0);
    step(1, 5);
    step(2, 0);
    step(3, 4);
    for (int t = 4; t < 150; t++)
      step(t, $urandom_range(0, 4));
`ifdef IFD_PERF_CNT_EN
    chk("issue_cnt", issue_cnt, exp_issues);
    chk("taken_cnt", taken_cnt, exp_taken);
`endif

    // Run 2: PC wrap from 0xFFF, then reset while an instruction is offered.
    rom[0]       = word(B,   2'd0, 16'h0000, 16'hAFFF);
    rom[12'hFFF] = word(NOP, 2'd3, 16'hBEEF, 16'h1234);
    do_reset();
    step(200, 0);
    step(201, 1);
    step(202, 2);
    chk("wrap_fetch_addr", bus.address, 12'hFFF);
    tick();
    tick();
    chk("wrap_issue_valid", bus.dec_valid, 1);
    chk("wrap_issue_a", bus.dec_a, 16'hBEEF);

    // Run 3: illegal opcode at address 3 halts permanently.
    rom[0] = word(NOP, 2'd0, 16'h0000, 16'h0000);
    rom[1] = word(NOP, 2'd1, 16'h0011, 16'h0022);
    rom[2] = word(ADD, 2'd2, 16'h0033, 16'h0044);
    rom[3] = word(4'($urandom_range(10, 15)), 2'd0, 16'h0055, 16'h0066);
    do_reset();
    step(300, 0);
    step(301, 2);
    step(302, 1);
    chk("halt_fetch_addr", bus.address, 3);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("halt_flag", bus.halted, 1);
      chk("halt_valid", bus.dec_valid, 0);
      chk("halt_addr", bus.address, 3);
      bus.dec_ready = 1'($urandom);
      bus.exec_idle = 1'($urandom);
      rand_flags();
      tick();
    end
    $display("txn 303 pc=003 halted");
    bus.dec_ready = 1'b0;
    bus.exec_idle = 1'b0;
    do_reset();
    step(304, 0);
    chk("post_halt_addr", bus.address, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Front end of the complex CPU: reads the 38-bit asynchronous instruction ROM and decodes each word.
- Owns the program counter and drives the ROM address.
- Issues non-branch instructions to the execute stage over a valid/ready handshake.
- Resolves b/bgt/blt/beq locally from flags returned by the execute stage.

Parameters:
- DATA_WIDTH, 38, instruction word width {opcode[3:0], s[1:0], a[15:0], b[15:0]}
- ADDR_WIDTH, 12, program counter / ROM address width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- address  output  ADDR_WIDTH  ROM address, equal to the PC
- instruction  input  DATA_WIDTH  ROM data, valid combinationally in the same cycle as address
- dec_valid  output  1  decoded instruction available
- dec_ready  input  1  execute stage accepts the instruction
- dec_opcode  output  4  opcode field
- dec_mode  output  2  s field
- dec_a  output  16  a field
- dec_b  output  16  b field
- exec_idle  input  1  all issued instructions retired; flags are current
- flag_gt, flag_lt, flag_eq  input  1 each  result of the last cmp
- halted  output  1  illegal opcode seen; fetch stopped

Behaviour:
- Single clock domain. rst is asynchronous, active-high.
- Reset values: PC=0, so address=0; state=FETCH; IR=0; dec_valid=0; dec_opcode/mode/a/b=0; halted=0.
- Reset asserted mid-operation clears dec_valid immediately, not at the next edge.

States:
- FETCH: address=PC. At the clock edge, IR<=instruction. Next state DECODE.
- DECODE:
  - Opcode 0101/0110/0111/1000 goes to BRANCH.
  - Opcode 0000-0100 and 1001 goes to ISSUE and loads the dec_* registers from IR.
  - Opcode 1010-1111 goes to HALT.
- ISSUE:
  - dec_valid=1; dec_* held stable while dec_ready=0.
  - On the cycle dec_valid&&dec_ready: PC<=PC+1, dec_valid<=0, next state FETCH.
- BRANCH:
  - Stays in BRANCH while exec_idle=0. No issue, PC held.
  - When exec_idle=1, taken = (op==0101) | (op==0110&&flag_gt) | (op==0111&&flag_lt) | (op==1000&&flag_eq).
  - PC<=taken ? IR.b[ADDR_WIDTH-1:0] : PC+1. Next state FETCH.
  - Branches are never presented on dec_valid.
- HALT: halted=1, dec_valid=0, PC frozen. Only reset exits.

Timing and arithmetic:
- Throughput: 3 cycles per instruction when dec_ready stays high. A branch takes at least 3 cycles.
- PC+1 is modulo 2^ADDR_WIDTH, so 0xFFF wraps to 0x000.
- Branch target bits of b above ADDR_WIDTH are ignored.
- Flags are sampled only in the cycle exec_idle=1 in BRANCH. Flag changes at any other time are ignored.

Optional Feature:
- Macro IFD_PERF_CNT_EN.
- When defined:
  - Adds output issue_cnt[15:0]: increments on every dec_valid&&dec_ready handshake.
  - Adds output taken_cnt[15:0]: increments on every taken branch.
  - Both saturate at 0xFFFF and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package cpu_isa_pkg holds:
  - opcode enum: NOP=0, MOV=1, LDR=2, STR=3, CMP=4, B=5, BGT=6, BLT=7, BEQ=8, ADD=9.
  - Field position constants: OP_MSB/LSB, S_MSB/LSB, A_MSB/LSB, B_MSB/LSB.
  - fsm_state_t enum: FETCH, DECODE, ISSUE, BRANCH, HALT.
  - is_branch() function.
- One natural sub-module, branch_resolve: combinational taken/target logic, instantiated inside.

Test Plan:
- Stream test:
  - Stimulus: ROM holds nop, mov r0,#1, mov r1,#2; dec_ready=1.
  - Required: address steps 0,1,2 every 3 cycles; dec_opcode/mode/a/b match each word (e.g. a=0x1000, b=0x0002).
- Backpressure:
  - Stimulus: dec_ready=0 for 5 cycles on mov r0,#1.
  - Required: dec_valid=1 and payload constant throughout; address unchanged; exactly one PC increment when ready rises.
- Conditional branch:
  - Stimulus: bgt to 0x062 at address 0x060, with exec_idle low 4 cycles then high.
  - Required with flag_gt=1: address held for those cycles, then 0x062. Required with flag_gt=0: next address is 0x061.
  - Repeat for blt/beq with flag_lt/flag_eq.
  - Unconditional b to 0x069: taken regardless of flags.
- Illegal opcode:
  - Stimulus: opcode 1010 at address 3.
  - Required: halted=1 and dec_valid=0 permanently; address stays 3; reset restores address=0 and halted=0.
- Wrap and reset:
  - Stimulus: nop at 0xFFF; then rst asserted mid-ISSUE, between clock edges.
  - Required: next address after 0xFFF is 0x000; on reset, dec_valid and address drop to 0 before the next clk edge.
